// File: rtl/matrix_reader.sv
// Read-side engine for the matrix store: looks up a matrix's dimensions and
// streams its elements in row-major order over a valid/ready interface.
module matrix_reader #(
  parameter int unsigned DATA_W  = 4,
  parameter int unsigned DIM_W   = 3,
  parameter int unsigned ID_W    = 3,
  parameter int unsigned MAX_DIM = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ID_W-1:0]   start_id,
  input  logic              abort,
  output logic [ID_W-1:0]   rd_matrix_id,
  output logic [DIM_W-1:0]  rd_row,
  output logic [DIM_W-1:0]  rd_col,
  input  logic [DATA_W-1:0] rd_data,
  input  logic [DIM_W-1:0]  rd_rows,
  input  logic [DIM_W-1:0]  rd_cols,
  input  logic              rd_id_valid,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [DIM_W-1:0]  out_row,
  output logic [DIM_W-1:0]  out_col,
  output logic              out_row_last,
  output logic              out_last,
  output logic [DIM_W-1:0]  mat_rows,
  output logic [DIM_W-1:0]  mat_cols,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [2:0] {
    IDLE, LOOKUP, CHECK, ISSUE, CAPTURE, OUT, DONE, ERR
  } state_t;

  state_t state;

  logic dims_bad_c;
  logic col_last_c;
  logic row_last_c;

  // A lookup fails on a missing matrix or an empty/oversized dimension
  assign dims_bad_c = !rd_id_valid
                    || (rd_rows == '0) || (rd_cols == '0)
                    || (rd_rows > DIM_W'(MAX_DIM))
                    || (rd_cols > DIM_W'(MAX_DIM));

  assign col_last_c = (rd_col == mat_cols - DIM_W'(1));
  assign row_last_c = (rd_row == mat_rows - DIM_W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      rd_matrix_id <= '0;
      rd_row       <= '0;
      rd_col       <= '0;
      out_valid    <= 1'b0;
      out_data     <= '0;
      out_row      <= '0;
      out_col      <= '0;
      out_row_last <= 1'b0;
      out_last     <= 1'b0;
      mat_rows     <= '0;
      mat_cols     <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
    end else if (abort) begin
      // Abort beats any handshake; in IDLE it also drops a coincident start
      state     <= IDLE;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            rd_matrix_id <= start_id;
            busy         <= 1'b1;
            state        <= LOOKUP;
          end
        end
        LOOKUP: state <= CHECK;
        CHECK: begin
          if (dims_bad_c) begin
            err   <= 1'b1;
            state <= ERR;
          end else begin
            mat_rows <= rd_rows;
            mat_cols <= rd_cols;
            rd_row   <= '0;
            rd_col   <= '0;
            state    <= ISSUE;
          end
        end
        ISSUE: state <= CAPTURE;
        CAPTURE: begin
          out_data     <= rd_data;
          out_row      <= rd_row;
          out_col      <= rd_col;
          out_row_last <= col_last_c;
          out_last     <= col_last_c && row_last_c;
          out_valid    <= 1'b1;
          state        <= OUT;
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (out_last) begin
              done  <= 1'b1;
              state <= DONE;
            end else begin
              // Advance the read address in row-major order
              if (out_row_last) begin
                rd_col <= '0;
                rd_row <= rd_row + DIM_W'(1);
              end else begin
                rd_col <= rd_col + DIM_W'(1);
              end
              state <= ISSUE;
            end
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        ERR: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_reader.sv
// Directed bench for matrix_reader with a registered store model and a
// scoreboard of expected beats checked at every output handshake.
module tb_matrix_reader;

  localparam int unsigned DATA_W  = 4;
  localparam int unsigned DIM_W   = 3;
  localparam int unsigned ID_W    = 3;
  localparam int unsigned MAX_DIM = 5;

  typedef struct packed {
    logic [DATA_W-1:0] d;
    logic [DIM_W-1:0]  r;
    logic [DIM_W-1:0]  c;
    logic              rl;
    logic              l;
  } beat_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [ID_W-1:0]   start_id = '0;
  logic              abort = 1'b0;
  logic [ID_W-1:0]   rd_matrix_id;
  logic [DIM_W-1:0]  rd_row;
  logic [DIM_W-1:0]  rd_col;
  logic [DATA_W-1:0] rd_data = '0;
  logic [DIM_W-1:0]  rd_rows = '0;
  logic [DIM_W-1:0]  rd_cols = '0;
  logic              rd_id_valid = 1'b0;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [DATA_W-1:0] out_data;
  logic [DIM_W-1:0]  out_row;
  logic [DIM_W-1:0]  out_col;
  logic              out_row_last;
  logic              out_last;
  logic [DIM_W-1:0]  mat_rows;
  logic [DIM_W-1:0]  mat_cols;
  logic              busy;
  logic              done;
  logic              err;

  logic [DATA_W-1:0] mem [8][8][8];
  logic [DIM_W-1:0]  dim_r [8];
  logic [DIM_W-1:0]  dim_c [8];
  logic              dim_v [8];

  beat_t exp_q[$];
  beat_t mon_e;

  int total = 0;
  int bad = 0;
  int hs_count = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int ov_cnt = 0;
  int cyc = 0;
  int prev_hs = -1;
  bit gap_chk = 1'b0;

  always #5 clk = ~clk;

  matrix_reader #(
    .DATA_W(DATA_W), .DIM_W(DIM_W), .ID_W(ID_W), .MAX_DIM(MAX_DIM)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .start_id(start_id), .abort(abort),
    .rd_matrix_id(rd_matrix_id), .rd_row(rd_row), .rd_col(rd_col),
    .rd_data(rd_data), .rd_rows(rd_rows), .rd_cols(rd_cols),
    .rd_id_valid(rd_id_valid), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_row(out_row), .out_col(out_col),
    .out_row_last(out_row_last), .out_last(out_last),
    .mat_rows(mat_rows), .mat_cols(mat_cols),
    .busy(busy), .done(done), .err(err)
  );

  // Store model: one-cycle registered read of element and dimensions
  always @(posedge clk) begin
    rd_data     <= mem[rd_matrix_id][rd_row][rd_col];
    rd_rows     <= dim_r[rd_matrix_id];
    rd_cols     <= dim_c[rd_matrix_id];
    rd_id_valid <= dim_v[rd_matrix_id];
    cyc         <= cyc + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Handshake monitor: sampled mid-cycle, ahead of the accepting edge
  always @(negedge clk) begin
    if (rst_n) begin
      if (done) done_cnt++;
      if (err) err_cnt++;
      if (out_valid) ov_cnt++;
      if (out_valid && out_ready && !abort) begin
        hs_count++;
        if (gap_chk) begin
          if (prev_hs >= 0) chk("beat_gap", 32'(cyc - prev_hs), 32'd3);
          prev_hs = cyc;
        end
        chk("beat_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          mon_e = exp_q.pop_front();
          chk("beat_data_pos", 32'({out_data, out_row, out_col}),
              32'({mon_e.d, mon_e.r, mon_e.c}));
          chk("beat_flags", 32'({out_row_last, out_last}), 32'({mon_e.rl, mon_e.l}));
        end
      end
    end
  end

  function automatic logic [31:0] all_outs();
    return 32'({rd_matrix_id, rd_row, rd_col, out_valid, out_data, out_row, out_col,
                out_row_last, out_last, mat_rows, mat_cols, busy, done, err});
  endfunction

  task automatic push_matrix(input int id);
    beat_t b;
    for (int r = 0; r < int'(dim_r[id]); r++) begin
      for (int c = 0; c < int'(dim_c[id]); c++) begin
        b.d  = mem[id][r][c];
        b.r  = DIM_W'(r);
        b.c  = DIM_W'(c);
        b.rl = (c == int'(dim_c[id]) - 1);
        b.l  = b.rl && (r == int'(dim_r[id]) - 1);
        exp_q.push_back(b);
      end
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int id);
    start_id = ID_W'(id);
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 200) begin
      tick(1);
      n++;
    end
    chk({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  task automatic wait_hs(input int target, input string tag);
    int n = 0;
    while (hs_count < target && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_hs_reached"}, 32'(hs_count >= target), 32'd1);
  endtask

  task automatic wait_ov(input string tag);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 200);
    chk({tag, "_ov"}, 32'(out_valid), 32'd1);
  endtask

  initial begin
    int base_hs, base_done, base_err, base_ov;
    logic [31:0] snap;
    int ids[3];

    for (int m = 0; m < 8; m++) begin
      dim_r[m] = '0;
      dim_c[m] = '0;
      dim_v[m] = 1'b0;
      for (int r = 0; r < 8; r++)
        for (int c = 0; c < 8; c++)
          mem[m][r][c] = DATA_W'(m + r + c);
    end
    dim_v[2] = 1'b1; dim_r[2] = 3'd2; dim_c[2] = 3'd3;
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 3; c++) mem[2][r][c] = DATA_W'(r * 3 + c + 1);
    dim_v[1] = 1'b1; dim_r[1] = 3'd1; dim_c[1] = 3'd1; mem[1][0][0] = 4'hF;
    dim_v[4] = 1'b1; dim_r[4] = 3'd3; dim_c[4] = 3'd3;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) mem[4][r][c] = DATA_W'(r * 3 + c + 7);
    dim_v[3] = 1'b1; dim_r[3] = 3'd2; dim_c[3] = 3'd0;
    dim_v[6] = 1'b1; dim_r[6] = 3'd6; dim_c[6] = 3'd2;

    // Reset values
    #12;
    chk("reset_outputs", all_outs(), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    tick(2);

    // 2x3 stream with ready high: latency and 3-cycle cadence
    base_hs = hs_count; base_done = done_cnt;
    push_matrix(2);
    gap_chk = 1'b1; prev_hs = -1;
    do_start(2);
    repeat (3) @(posedge clk);
    @(negedge clk) chk("ov_t4", 32'(out_valid), 32'd0);
    @(posedge clk);
    @(negedge clk) chk("ov_t5", 32'(out_valid), 32'd1);
    wait_idle("s1");
    gap_chk = 1'b0;
    chk("s1_beats", 32'(hs_count - base_hs), 32'd6);
    chk("s1_done", 32'(done_cnt - base_done), 32'd1);
    chk("s1_dims", 32'({mat_rows, mat_cols}), 32'({3'd2, 3'd3}));
    chk("s1_q_empty", 32'(exp_q.size()), 32'd0);

    // Backpressure on beat 2
    base_hs = hs_count;
    push_matrix(2);
    do_start(2);
    wait_hs(base_hs + 1, "s2a");
    tick(1);
    out_ready = 1'b0;
    wait_ov("s2_stall");
    snap = 32'({out_data, out_row, out_col, out_row_last, out_last});
    chk("s2_beat2", snap, 32'({4'd2, 3'd0, 3'd1, 1'b0, 1'b0}));
    repeat (4) begin
      @(negedge clk);
      chk("s2_hold", 32'({out_valid, out_data, out_row, out_col, out_row_last, out_last}),
          32'({1'b1, snap[11:0]}));
    end
    tick(1);
    out_ready = 1'b1;
    wait_idle("s2");
    chk("s2_beats", 32'(hs_count - base_hs), 32'd6);
    chk("s2_q_empty", 32'(exp_q.size()), 32'd0);

    // Failed lookups: missing matrix, zero columns, oversize rows
    ids[0] = 5; ids[1] = 3; ids[2] = 6;
    foreach (ids[k]) begin
      base_err = err_cnt; base_ov = ov_cnt;
      do_start(ids[k]);
      tick(1);
      chk("err_busy", 32'({busy, err}), 32'({1'b1, 1'b0}));
      tick(1);
      chk("err_pulse", 32'({busy, err}), 32'({1'b1, 1'b1}));
      tick(1);
      chk("err_end", 32'({busy, err}), 32'd0);
      tick(2);
      chk("err_count", 32'(err_cnt - base_err), 32'd1);
      chk("err_no_ov", 32'(ov_cnt - base_ov), 32'd0);
    end

    // 1x1 matrix
    base_hs = hs_count; base_done = done_cnt;
    push_matrix(1);
    do_start(1);
    wait_idle("s4");
    chk("s4_beats", 32'(hs_count - base_hs), 32'd1);
    chk("s4_done", 32'(done_cnt - base_done), 32'd1);

    // abort and start together in IDLE: start dropped
    abort = 1'b1; start = 1'b1; start_id = 3'd2;
    tick(1);
    abort = 1'b0; start = 1'b0;
    chk("abort_start_idle", 32'(busy), 32'd0);
    tick(2);

    // 3x3 with a second start during the stream
    base_hs = hs_count;
    push_matrix(4);
    do_start(4);
    wait_hs(base_hs + 4, "s5a");
    tick(1);
    start_id = 3'd2; start = 1'b1;
    tick(1);
    start = 1'b0;
    chk("s5_id_kept", 32'(rd_matrix_id), 32'd4);
    wait_idle("s5");
    chk("s5_beats", 32'(hs_count - base_hs), 32'd9);
    chk("s5_q_empty", 32'(exp_q.size()), 32'd0);

    // Abort while beat 6 waits with ready low
    base_hs = hs_count; base_done = done_cnt;
    push_matrix(4);
    do_start(4);
    wait_hs(base_hs + 5, "s6a");
    tick(1);
    out_ready = 1'b0;
    wait_ov("s6_b6");
    tick(1);
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    chk("s6_abort", 32'({out_valid, busy}), 32'd0);
    out_ready = 1'b1;
    tick(5);
    chk("s6_no_done", 32'(done_cnt - base_done), 32'd0);
    chk("s6_beats", 32'(hs_count - base_hs), 32'd5);
    chk("s6_q_left", 32'(exp_q.size()), 32'd4);
    exp_q.delete();

    // Reset mid-stream, then a full restart
    push_matrix(4);
    base_hs = hs_count;
    do_start(4);
    wait_hs(base_hs + 3, "s7a");
    @(posedge clk); #2 rst_n = 1'b0;
    #1 chk("s7_reset_outputs", all_outs(), 32'd0);
    exp_q.delete();
    @(posedge clk); #1 rst_n = 1'b1;
    tick(1);
    base_hs = hs_count; base_done = done_cnt;
    push_matrix(4);
    do_start(4);
    wait_idle("s7");
    chk("s7_beats", 32'(hs_count - base_hs), 32'd9);
    chk("s7_done", 32'(done_cnt - base_done), 32'd1);
    chk("s7_q_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
